id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
MIPS32 instruction-decode stage; sits directly upstream of reg_file and consumes its two read ports.
- Decodes the IF/ID instruction and drives reg_file read addresses/enables.
- Resolves operands (EX/MEM forwarding), resolves BEQ/BNE, detects load-use hazards.
- Registers the decoded bundle into the ID/EX pipeline register.

Parameters:
none

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-low
if_pc  in  32  PC of instruction in ID
if_inst  in  32  instruction word
if_valid  in  1  if_inst is a real instruction
stall_in  in  1  downstream hold; ID/EX register keeps its value
flush  in  1  squash; ID/EX loads a bubble
rd_en1  out  1  reg_file port-1 read enable
rdaddr1  out  5  reg_file port-1 address (rs)
rddata1  in  32  reg_file port-1 data
rd_en2  out  1  reg_file port-2 read enable
rdaddr2  out  5  reg_file port-2 address (rt)
rddata2  in  32  reg_file port-2 data
ex_wr_en  in  1  EX-stage instruction writes a register
ex_wraddr  in  5  EX destination
ex_wrdata  in  32  EX result
ex_is_load  in  1  EX instruction is LW
mem_wr_en  in  1  MEM-stage instruction writes a register
mem_wraddr  in  5  MEM destination
mem_wrdata  in  32  MEM result
stall_req  out  1  combinational; IF/PC must hold
branch_taken  out  1  combinational; redirect PC
branch_target  out  32  combinational; if_pc+4+(sext(imm16)<<2)
idex_valid  out  1  registered; bundle valid
idex_aluop  out  4  registered; 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLL,8 SRL,9 SRA
idex_src1  out  32  registered operand A
idex_src2  out  32  registered operand B
idex_wreg  out  1  registered; write-back enable
idex_wd  out  5  registered destination address
idex_memop  out  2  registered; 0 none,1 LW,2 SW
idex_store_data  out  32  registered SW data (resolved rt)

Behaviour:
- Decode set: ADDU SUBU AND OR XOR NOR SLT SLL SRL SRA (R-type); ADDIU (sext), ANDI/ORI/XORI (zext), LUI (OR, src1=0, src2=imm<<16), LW/SW (ADD, src2=sext imm), BEQ, BNE. Any other encoding, or if_valid=0 → bubble.
- rd_en1=1 when rs is used; rd_en2=1 when rt is used (R-type, SW, BEQ/BNE). Unused ports: enable 0, address 0.
- Shifts: src1=rt value, src2=zext(shamt). Destination: rd for R-type, rt for I-type; wreg=0 for SW/BEQ/BNE and for dest 0.
- Operand resolve per used source: addr 0 → 0; else EX match (ex_wr_en, same addr) → ex_wrdata; else MEM match → mem_wrdata; else rddata. EX has priority over MEM; WB bypass is done inside reg_file.
- stall_req=1 when ex_is_load & ex_wr_en & ex_wraddr≠0 & ex_wraddr equals a used source.
- BEQ/BNE compare resolved operands. branch_taken=1 only if if_valid & !stall_req & !flush. Delay slot executes normally.
- ID/EX update priority at posedge: rst=0 → all idex_* = 0; else flush → bubble; else stall_in → hold; else stall_req → bubble; else load decoded bundle.
- Bubble = idex_valid 0, all other idex_* 0.
- Reset mid-stream drops the in-flight bundle; combinational outputs follow current inputs regardless of rst.

Optional Feature:
ID_FWD_EN — defined: EX/MEM forwarding exactly as above. Undefined: forwarding muxes removed (operand = rddata or 0 for addr 0); stall_req also asserts when any used nonzero source matches ex_wraddr (ex_wr_en) or mem_wraddr (mem_wr_en).

Test Plan:
- rst=0 for 2 cycles with ADDU if_inst → all idex_* 0; rst=1 then ORI r2,r0,0x8001 → next cycle idex_aluop=3, src1=0, src2=0x00008001, wd=2, wreg=1.
- ADDU r3,r1,r2 with rddata1=5, rddata2=7, ex_wr_en=1, ex_wraddr=1, ex_wrdata=9 → src1=9, src2=7 (FWD_EN); undefined: stall_req=1 and bubble.
- ex_is_load=1, ex_wraddr=4, inst SW r4,8(r5) → stall_req=1, idex_valid=0 next cycle; ex_is_load=0 → SW loads with memop=2.
- BEQ r1,r1,-1 at if_pc=0x100 → branch_taken=1, branch_target=0x100; BNE on same operands → branch_taken=0.
- stall_in=1 two cycles with changing if_inst → idex_* hold; flush=1 with stall_in=1 → bubble.
- LUI r7,0xABCD with rddata forced 0xFFFFFFFF on rt=7 → src2=0xABCD0000, rd_en1=0, write to r0 instruction gives wreg=0.

Source files
------------

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID inputs, reg_file read ports, EX/MEM bypass inputs and ID/EX outputs of the decode stage
interface id_stage_if;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall_in;
    logic        flush;
    logic        rd_en1;
    logic [4:0]  rdaddr1;
    logic [31:0] rddata1;
    logic        rd_en2;
    logic [4:0]  rdaddr2;
    logic [31:0] rddata2;
    logic        ex_wr_en;
    logic [4:0]  ex_wraddr;
    logic [31:0] ex_wrdata;
    logic        ex_is_load;
    logic        mem_wr_en;
    logic [4:0]  mem_wraddr;
    logic [31:0] mem_wrdata;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        idex_valid;
    logic [3:0]  idex_aluop;
    logic [31:0] idex_src1;
    logic [31:0] idex_src2;
    logic        idex_wreg;
    logic [4:0]  idex_wd;
    logic [1:0]  idex_memop;
    logic [31:0] idex_store_data;
    modport master (
        output if_pc, if_inst, if_valid, stall_in, flush, rddata1, rddata2,
               ex_wr_en, ex_wraddr, ex_wrdata, ex_is_load, mem_wr_en, mem_wraddr, mem_wrdata,
        input  rd_en1, rdaddr1, rd_en2, rdaddr2, stall_req, branch_taken, branch_target,
               idex_valid, idex_aluop, idex_src1, idex_src2, idex_wreg, idex_wd, idex_memop, idex_store_data
    );
    modport slave (
        input  if_pc, if_inst, if_valid, stall_in, flush, rddata1, rddata2,
               ex_wr_en, ex_wraddr, ex_wrdata, ex_is_load, mem_wr_en, mem_wraddr, mem_wrdata,
        output rd_en1, rdaddr1, rd_en2, rdaddr2, stall_req, branch_taken, branch_target,
               idex_valid, idex_aluop, idex_src1, idex_src2, idex_wreg, idex_wd, idex_memop, idex_store_data
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: MIPS32 decode, operand resolve, BEQ/BNE resolve, load-use hazard and ID/EX register; define ID_FWD_EN for EX/MEM forwarding, otherwise any pending producer of a used source stalls
module id_stage (
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        wreg;
        logic [4:0]  wd;
        logic [1:0]  memop;
        logic [31:0] store_data;
    } idex_t;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;
    logic [31:0] w_sext, w_zext, w_imm;
    logic        w_ok, w_use_rs, w_use_rt, w_shift, w_use_imm, w_rtype, w_wr, w_beq, w_bne, w_valid;
    logic [3:0]  w_aluop;
    logic [1:0]  w_memop;
    logic [4:0]  w_rdaddr1, w_rdaddr2;
    logic        w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2, w_stall, w_eq;
    logic [31:0] w_rs_val, w_rt_val;
    idex_t       w_dec, r_idex;

    assign w_op    = bus.if_inst[31:26];
    assign w_rs    = bus.if_inst[25:21];
    assign w_rt    = bus.if_inst[20:16];
    assign w_rd    = bus.if_inst[15:11];
    assign w_shamt = bus.if_inst[10:6];
    assign w_funct = bus.if_inst[5:0];
    assign w_imm16 = bus.if_inst[15:0];
    assign w_sext  = {{16{w_imm16[15]}}, w_imm16};
    assign w_zext  = {16'd0, w_imm16};

    // Decode opcode/funct into operand usage, ALU op, immediate form and write-back intent
    always_comb begin
        w_ok      = 1'b1;
        w_use_rs  = 1'b1;
        w_use_rt  = 1'b0;
        w_shift   = 1'b0;
        w_use_imm = 1'b1;
        w_rtype   = 1'b0;
        w_wr      = 1'b1;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_aluop   = 4'd0;
        w_imm     = w_sext;
        w_memop   = 2'd0;
        case (w_op)
            6'h00: begin
                w_rtype   = 1'b1;
                w_use_rt  = 1'b1;
                w_use_imm = 1'b0;
                case (w_funct)
                    6'h21: w_aluop = 4'd0;
                    6'h23: w_aluop = 4'd1;
                    6'h24: w_aluop = 4'd2;
                    6'h25: w_aluop = 4'd3;
                    6'h26: w_aluop = 4'd4;
                    6'h27: w_aluop = 4'd5;
                    6'h2a: w_aluop = 4'd6;
                    6'h00: begin w_aluop = 4'd7; w_shift = 1'b1; w_use_rs = 1'b0; end
                    6'h02: begin w_aluop = 4'd8; w_shift = 1'b1; w_use_rs = 1'b0; end
                    6'h03: begin w_aluop = 4'd9; w_shift = 1'b1; w_use_rs = 1'b0; end
                    default: w_ok = 1'b0;
                endcase
            end
            6'h09: w_aluop = 4'd0;
            6'h0c: begin w_aluop = 4'd2; w_imm = w_zext; end
            6'h0d: begin w_aluop = 4'd3; w_imm = w_zext; end
            6'h0e: begin w_aluop = 4'd4; w_imm = w_zext; end
            6'h0f: begin w_aluop = 4'd3; w_use_rs = 1'b0; w_imm = {w_imm16, 16'd0}; end
            6'h23: w_memop = 2'd1;
            6'h2b: begin w_memop = 2'd2; w_use_rt = 1'b1; w_wr = 1'b0; end
            6'h04: begin w_beq = 1'b1; w_use_rt = 1'b1; w_use_imm = 1'b0; w_wr = 1'b0; end
            6'h05: begin w_bne = 1'b1; w_use_rt = 1'b1; w_use_imm = 1'b0; w_wr = 1'b0; end
            default: w_ok = 1'b0;
        endcase
    end

    assign w_valid     = bus.if_valid && w_ok;
    assign w_rdaddr1   = (w_valid && w_use_rs) ? w_rs : 5'd0;
    assign w_rdaddr2   = (w_valid && w_use_rt) ? w_rt : 5'd0;
    assign bus.rd_en1  = w_valid && w_use_rs;
    assign bus.rd_en2  = w_valid && w_use_rt;
    assign bus.rdaddr1 = w_rdaddr1;
    assign bus.rdaddr2 = w_rdaddr2;

    // An unused source carries address 0, so it can never match a producer
    assign w_ex_hit1  = bus.ex_wr_en && bus.ex_wraddr != 5'd0 && bus.ex_wraddr == w_rdaddr1;
    assign w_ex_hit2  = bus.ex_wr_en && bus.ex_wraddr != 5'd0 && bus.ex_wraddr == w_rdaddr2;
    assign w_mem_hit1 = bus.mem_wr_en && bus.mem_wraddr != 5'd0 && bus.mem_wraddr == w_rdaddr1;
    assign w_mem_hit2 = bus.mem_wr_en && bus.mem_wraddr != 5'd0 && bus.mem_wraddr == w_rdaddr2;

`ifdef ID_FWD_EN
    assign w_rs_val = w_ex_hit1 ? bus.ex_wrdata : w_mem_hit1 ? bus.mem_wrdata : w_rdaddr1 == 5'd0 ? 32'd0 : bus.rddata1;
    assign w_rt_val = w_ex_hit2 ? bus.ex_wrdata : w_mem_hit2 ? bus.mem_wrdata : w_rdaddr2 == 5'd0 ? 32'd0 : bus.rddata2;
    assign w_stall  = bus.ex_is_load && (w_ex_hit1 || w_ex_hit2);
`else
    assign w_rs_val = w_rdaddr1 == 5'd0 ? 32'd0 : bus.rddata1;
    assign w_rt_val = w_rdaddr2 == 5'd0 ? 32'd0 : bus.rddata2;
    assign w_stall  = w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
`endif

    assign w_eq              = w_rs_val == w_rt_val;
    assign bus.stall_req     = w_stall;
    assign bus.branch_taken  = w_valid && (w_beq ? w_eq : (w_bne && !w_eq)) && !w_stall && !bus.flush;
    assign bus.branch_target = bus.if_pc + 32'd4 + {w_sext[29:0], 2'b00};

    // Assemble the decoded ID/EX bundle; unrecognised or invalid instructions become a bubble
    always_comb begin
        w_dec = '0;
        if (w_valid) begin
            w_dec.valid      = 1'b1;
            w_dec.aluop      = w_aluop;
            w_dec.src1       = w_shift ? w_rt_val : w_rs_val;
            w_dec.src2       = w_shift ? {27'd0, w_shamt} : w_use_imm ? w_imm : w_rt_val;
            w_dec.wd         = w_wr ? (w_rtype ? w_rd : w_rt) : 5'd0;
            w_dec.wreg       = w_wr && w_dec.wd != 5'd0;
            w_dec.memop      = w_memop;
            w_dec.store_data = w_memop == 2'd2 ? w_rt_val : 32'd0;
        end
    end

    // ID/EX register: reset and flush clear, downstream hold keeps, a hazard stall inserts a bubble
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) r_idex <= '0;
        else if (!bus.stall_in) r_idex <= w_stall ? '0 : w_dec;
    end

    assign bus.idex_valid      = r_idex.valid;
    assign bus.idex_aluop      = r_idex.aluop;
    assign bus.idex_src1       = r_idex.src1;
    assign bus.idex_src2       = r_idex.src2;
    assign bus.idex_wreg       = r_idex.wreg;
    assign bus.idex_wd         = r_idex.wd;
    assign bus.idex_memop      = r_idex.memop;
    assign bus.idex_store_data = r_idex.store_data;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed decode/forward/hazard/branch/ID-EX checks for id_stage (ID_FWD_EN selects the forwarding expectations)
module tb_id_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] r_enc(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_pc = 32'h0; bus.if_inst = 32'h0; bus.if_valid = 1'b1;
        bus.stall_in = 1'b0; bus.flush = 1'b0; bus.rddata1 = 32'h0; bus.rddata2 = 32'h0;
        bus.ex_wr_en = 1'b0; bus.ex_wraddr = 5'd0; bus.ex_wrdata = 32'h0; bus.ex_is_load = 1'b0;
        bus.mem_wr_en = 1'b0; bus.mem_wraddr = 5'd0; bus.mem_wrdata = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.rddata1 = 32'd5; bus.rddata2 = 32'd7;
        tick(); tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wreg, bus.idex_wd, bus.idex_memop, bus.idex_store_data} !== 109'd0) begin n_err++; $display("FAIL reset_bundle valid=%b src1=%h src2=%h wd=%0d expected all zero", bus.idex_valid, bus.idex_src1, bus.idex_src2, bus.idex_wd); end
        n_cmp++; if (bus.rdaddr1 !== 5'd1) begin n_err++; $display("FAIL reset_comb_rdaddr1 got=%0d exp=1", bus.rdaddr1); end
        rst = 1'b1;
        bus.if_inst = i_enc(6'h0d, 5'd0, 5'd2, 16'h8001);
        tick();
        n_cmp++; if (bus.idex_aluop !== 4'd3) begin n_err++; $display("FAIL ori_aluop got=%0d exp=3", bus.idex_aluop); end
        n_cmp++; if (bus.idex_src1 !== 32'd0) begin n_err++; $display("FAIL ori_src1 got=%h exp=0", bus.idex_src1); end
        n_cmp++; if (bus.idex_src2 !== 32'h00008001) begin n_err++; $display("FAIL ori_src2 got=%h exp=00008001", bus.idex_src2); end
        n_cmp++; if ({bus.idex_valid, bus.idex_wreg, bus.idex_wd} !== {1'b1, 1'b1, 5'd2}) begin n_err++; $display("FAIL ori_dest valid=%b wreg=%b wd=%0d exp 1 1 2", bus.idex_valid, bus.idex_wreg, bus.idex_wd); end
    endtask

    task automatic test_forward();
        idle();
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.rddata1 = 32'd5; bus.rddata2 = 32'd7;
        bus.ex_wr_en = 1'b1; bus.ex_wraddr = 5'd1; bus.ex_wrdata = 32'd9;
        #1;
        n_cmp++; if ({bus.rd_en1, bus.rdaddr1, bus.rd_en2, bus.rdaddr2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin n_err++; $display("FAIL addu_ports en1=%b a1=%0d en2=%b a2=%0d exp 1 1 1 2", bus.rd_en1, bus.rdaddr1, bus.rd_en2, bus.rdaddr2); end
`ifdef ID_FWD_EN
        n_cmp++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL fwd_nostall got=%b exp=0", bus.stall_req); end
        tick();
        n_cmp++; if ({bus.idex_src1, bus.idex_src2} !== {32'd9, 32'd7}) begin n_err++; $display("FAIL fwd_ex src1=%h src2=%h exp 9 7", bus.idex_src1, bus.idex_src2); end
        bus.mem_wr_en = 1'b1; bus.mem_wraddr = 5'd1; bus.mem_wrdata = 32'h33;
        tick();
        n_cmp++; if (bus.idex_src1 !== 32'd9) begin n_err++; $display("FAIL fwd_ex_priority got=%h exp=9", bus.idex_src1); end
        bus.ex_wr_en = 1'b0;
        tick();
        n_cmp++; if (bus.idex_src1 !== 32'h33) begin n_err++; $display("FAIL fwd_mem got=%h exp=33", bus.idex_src1); end
`else
        n_cmp++; if (bus.stall_req !== 1'b1) begin n_err++; $display("FAIL nofwd_ex_stall got=%b exp=1", bus.stall_req); end
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_src1} !== 33'd0) begin n_err++; $display("FAIL nofwd_bubble valid=%b src1=%h exp 0 0", bus.idex_valid, bus.idex_src1); end
        bus.ex_wr_en = 1'b0; bus.mem_wr_en = 1'b1; bus.mem_wraddr = 5'd2;
        #1;
        n_cmp++; if (bus.stall_req !== 1'b1) begin n_err++; $display("FAIL nofwd_mem_stall got=%b exp=1", bus.stall_req); end
        bus.mem_wr_en = 1'b0;
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_src1, bus.idex_src2} !== {1'b1, 32'd5, 32'd7}) begin n_err++; $display("FAIL nofwd_regfile valid=%b src1=%h src2=%h exp 1 5 7", bus.idex_valid, bus.idex_src1, bus.idex_src2); end
`endif
        idle();
        bus.if_inst = r_enc(5'd0, 5'd2, 5'd3, 5'd0, 6'h21); bus.rddata1 = 32'h55; bus.rddata2 = 32'd7;
        bus.ex_wr_en = 1'b1; bus.ex_wraddr = 5'd0; bus.ex_wrdata = 32'd9;
        #1;
        n_cmp++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL r0_nostall got=%b exp=0", bus.stall_req); end
        tick();
        n_cmp++; if (bus.idex_src1 !== 32'd0) begin n_err++; $display("FAIL r0_src1 got=%h exp=0", bus.idex_src1); end
    endtask

    task automatic test_load_use();
        idle();
        bus.if_inst = i_enc(6'h2b, 5'd5, 5'd4, 16'd8);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wraddr = 5'd4;
        #1;
        n_cmp++; if ({bus.stall_req, bus.rd_en2, bus.rdaddr2, bus.rdaddr1} !== {1'b1, 1'b1, 5'd4, 5'd5}) begin n_err++; $display("FAIL sw_hazard stall=%b en2=%b a2=%0d a1=%0d exp 1 1 4 5", bus.stall_req, bus.rd_en2, bus.rdaddr2, bus.rdaddr1); end
        tick();
        n_cmp++; if (bus.idex_valid !== 1'b0) begin n_err++; $display("FAIL sw_bubble got=%b exp=0", bus.idex_valid); end
        bus.ex_is_load = 1'b0; bus.ex_wr_en = 1'b0; bus.rddata1 = 32'h100; bus.rddata2 = 32'hDEAD;
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_memop, bus.idex_wreg, bus.idex_aluop} !== {1'b1, 2'd2, 1'b0, 4'd0}) begin n_err++; $display("FAIL sw_ctrl valid=%b memop=%0d wreg=%b aluop=%0d exp 1 2 0 0", bus.idex_valid, bus.idex_memop, bus.idex_wreg, bus.idex_aluop); end
        n_cmp++; if ({bus.idex_src1, bus.idex_src2, bus.idex_store_data} !== {32'h100, 32'd8, 32'hDEAD}) begin n_err++; $display("FAIL sw_data src1=%h src2=%h sd=%h exp 100 8 dead", bus.idex_src1, bus.idex_src2, bus.idex_store_data); end
        bus.if_inst = i_enc(6'h23, 5'd4, 5'd6, 16'hFFFC);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wraddr = 5'd4;
        #1;
        n_cmp++; if (bus.stall_req !== 1'b1) begin n_err++; $display("FAIL lw_rs_hazard got=%b exp=1", bus.stall_req); end
        bus.if_inst = i_enc(6'h09, 5'd1, 5'd6, 16'd4); bus.ex_wraddr = 5'd6;
        #1;
        n_cmp++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL unused_rt_nostall got=%b exp=0", bus.stall_req); end
        bus.if_inst = i_enc(6'h23, 5'd0, 5'd6, 16'hFFFC); bus.ex_wraddr = 5'd0; bus.rddata1 = 32'h77;
        #1;
        n_cmp++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL load_r0_nostall got=%b exp=0", bus.stall_req); end
        tick();
        n_cmp++; if ({bus.idex_memop, bus.idex_src1, bus.idex_src2, bus.idex_wd, bus.idex_wreg} !== {2'd1, 32'd0, 32'hFFFFFFFC, 5'd6, 1'b1}) begin n_err++; $display("FAIL lw_bundle memop=%0d src1=%h src2=%h wd=%0d wreg=%b exp 1 0 fffffffc 6 1", bus.idex_memop, bus.idex_src1, bus.idex_src2, bus.idex_wd, bus.idex_wreg); end
    endtask

    task automatic test_branch();
        idle();
        bus.if_pc = 32'h100; bus.if_inst = i_enc(6'h04, 5'd1, 5'd1, 16'hFFFF); bus.rddata1 = 32'd5; bus.rddata2 = 32'd5;
        #1;
        n_cmp++; if ({bus.branch_taken, bus.branch_target} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL beq_taken taken=%b target=%h exp 1 100", bus.branch_taken, bus.branch_target); end
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL beq_flush got=%b exp=0", bus.branch_taken); end
        bus.flush = 1'b0; bus.if_inst = i_enc(6'h05, 5'd1, 5'd1, 16'hFFFF);
        #1;
        n_cmp++; if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL bne_equal got=%b exp=0", bus.branch_taken); end
        bus.if_pc = 32'h200; bus.if_inst = i_enc(6'h05, 5'd1, 5'd2, 16'd3); bus.rddata2 = 32'd6;
        #1;
        n_cmp++; if ({bus.branch_taken, bus.branch_target} !== {1'b1, 32'h210}) begin n_err++; $display("FAIL bne_taken taken=%b target=%h exp 1 210", bus.branch_taken, bus.branch_target); end
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wraddr = 5'd2;
        #1;
        n_cmp++; if ({bus.stall_req, bus.branch_taken} !== 2'b10) begin n_err++; $display("FAIL bne_stalled stall=%b taken=%b exp 1 0", bus.stall_req, bus.branch_taken); end
        bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0; bus.if_valid = 1'b0;
        #1;
        n_cmp++; if (bus.branch_taken !== 1'b0) begin n_err++; $display("FAIL bne_invalid got=%b exp=0", bus.branch_taken); end
    endtask

    task automatic test_stall_hold();
        idle();
        bus.if_inst = i_enc(6'h09, 5'd1, 5'd9, 16'hFFFE); bus.rddata1 = 32'd10;
        tick();
        n_cmp++; if ({bus.idex_src1, bus.idex_src2} !== {32'd10, 32'hFFFFFFFE}) begin n_err++; $display("FAIL addiu src1=%h src2=%h exp a fffffffe", bus.idex_src1, bus.idex_src2); end
        bus.stall_in = 1'b1; bus.if_inst = i_enc(6'h0e, 5'd1, 5'd10, 16'h00F0);
        tick();
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd11, 5'd0, 6'h27);
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_aluop, bus.idex_src2, bus.idex_wd} !== {1'b1, 4'd0, 32'hFFFFFFFE, 5'd9}) begin n_err++; $display("FAIL hold valid=%b aluop=%0d src2=%h wd=%0d exp 1 0 fffffffe 9", bus.idex_valid, bus.idex_aluop, bus.idex_src2, bus.idex_wd); end
        bus.flush = 1'b1;
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wreg, bus.idex_wd} !== 75'd0) begin n_err++; $display("FAIL flush_over_stall valid=%b src1=%h wd=%0d exp all zero", bus.idex_valid, bus.idex_src1, bus.idex_wd); end
    endtask

    task automatic test_alu_ops();
        logic [5:0] fn [7] = '{6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02};
        logic [3:0] op [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
        idle();
        for (int i = 0; i < 7; i++) begin
            bus.if_inst = r_enc(5'd1, 5'd2, 5'd8, 5'd1, fn[i]);
            tick();
            n_cmp++; if ({bus.idex_aluop, bus.idex_wd} !== {op[i], 5'd8}) begin n_err++; $display("FAIL aluop_funct%h aluop=%0d wd=%0d exp %0d 8", fn[i], bus.idex_aluop, bus.idex_wd, op[i]); end
        end
    endtask

    task automatic test_lui_misc();
        idle();
        bus.if_inst = i_enc(6'h0f, 5'd0, 5'd7, 16'hABCD); bus.rddata1 = 32'hFFFFFFFF; bus.rddata2 = 32'hFFFFFFFF;
        #1;
        n_cmp++; if ({bus.rd_en1, bus.rd_en2, bus.rdaddr1, bus.rdaddr2} !== 12'd0) begin n_err++; $display("FAIL lui_ports en1=%b en2=%b a1=%0d a2=%0d exp all 0", bus.rd_en1, bus.rd_en2, bus.rdaddr1, bus.rdaddr2); end
        tick();
        n_cmp++; if ({bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wd} !== {4'd3, 32'd0, 32'hABCD0000, 5'd7}) begin n_err++; $display("FAIL lui aluop=%0d src1=%h src2=%h wd=%0d exp 3 0 abcd0000 7", bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wd); end
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd0, 5'd0, 6'h21);
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_wreg} !== 2'b10) begin n_err++; $display("FAIL dest_r0 valid=%b wreg=%b exp 1 0", bus.idex_valid, bus.idex_wreg); end
        bus.if_inst = r_enc(5'd0, 5'd2, 5'd4, 5'd3, 6'h03); bus.rddata2 = 32'h80;
        #1;
        n_cmp++; if ({bus.rd_en1, bus.rd_en2, bus.rdaddr2} !== {1'b0, 1'b1, 5'd2}) begin n_err++; $display("FAIL sra_ports en1=%b en2=%b a2=%0d exp 0 1 2", bus.rd_en1, bus.rd_en2, bus.rdaddr2); end
        tick();
        n_cmp++; if ({bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wd} !== {4'd9, 32'h80, 32'd3, 5'd4}) begin n_err++; $display("FAIL sra aluop=%0d src1=%h src2=%h wd=%0d exp 9 80 3 4", bus.idex_aluop, bus.idex_src1, bus.idex_src2, bus.idex_wd); end
        bus.if_inst = i_enc(6'h0c, 5'd1, 5'd5, 16'h8000); bus.rddata1 = 32'h1234;
        tick();
        n_cmp++; if ({bus.idex_aluop, bus.idex_src1, bus.idex_src2} !== {4'd2, 32'h1234, 32'h00008000}) begin n_err++; $display("FAIL andi aluop=%0d src1=%h src2=%h exp 2 1234 00008000", bus.idex_aluop, bus.idex_src1, bus.idex_src2); end
        bus.if_inst = i_enc(6'h3f, 5'd1, 5'd5, 16'h1);
        tick();
        n_cmp++; if (bus.idex_valid !== 1'b0) begin n_err++; $display("FAIL illegal_bubble got=%b exp=0", bus.idex_valid); end
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.if_valid = 1'b0;
        tick();
        n_cmp++; if ({bus.idex_valid, bus.rd_en1, bus.idex_src1} !== 34'd0) begin n_err++; $display("FAIL if_invalid valid=%b en1=%b src1=%h exp 0 0 0", bus.idex_valid, bus.rd_en1, bus.idex_src1); end
    endtask

    task automatic test_reset_midstream();
        idle();
        bus.if_inst = r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h21); bus.rddata1 = 32'd1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if ({bus.idex_valid, bus.idex_src1, bus.idex_wd} !== 38'd0) begin n_err++; $display("FAIL midstream_reset valid=%b src1=%h wd=%0d exp 0 0 0", bus.idex_valid, bus.idex_src1, bus.idex_wd); end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_stall_hold();
        test_alu_ops();
        test_lui_misc();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
